// File: rtl/tetris_pkg.sv
// Shared board geometry, game-state codes and beat payload for the board row transmitter.
package tetris_pkg;

  localparam int unsigned ROWS        = 8;
  localparam int unsigned COLS        = 4;
  localparam int unsigned BOARD_W     = ROWS * COLS;
  localparam int unsigned ROW_W       = $clog2(ROWS);
  localparam int unsigned ST_W        = 3;
  localparam int unsigned DROP_W      = 8;
  localparam int unsigned GAP_CYC_DEF = 4;

  localparam logic [ST_W-1:0] ST_GEN     = 3'b000;
  localparam logic [ST_W-1:0] ST_MOVING  = 3'b001;
  localparam logic [ST_W-1:0] ST_CLEAR   = 3'b011;
  // Reset value of the previous-state tracker: never a real state, so GEN held through reset triggers.
  localparam logic [ST_W-1:0] ST_NONE    = 3'b111;

  typedef struct packed {
    logic [COLS-1:0]  data;
    logic [ROW_W-1:0] row;
    logic             sof;
    logic             eof;
    logic             full;
  } beat_t;

  function automatic logic [COLS-1:0] row_slice(input logic [BOARD_W-1:0] board,
                                                input logic [ROW_W-1:0]   idx);
    return board[int'(idx) * COLS +: COLS];
  endfunction

  function automatic beat_t make_beat(input logic [COLS-1:0]  data,
                                      input logic [ROW_W-1:0] row);
    beat_t b;
    b.data = data;
    b.row  = row;
    b.sof  = (row == ROW_W'(0));
    b.eof  = (row == ROW_W'(ROWS - 1));
    b.full = &data;
    return b;
  endfunction

endpackage

// File: rtl/board_row_tx_if.sv
// Valid/ready row-beat link from the board transmitter to the display driver.
interface board_row_tx_if;
  import tetris_pkg::*;

  logic             tx_valid;
  logic             tx_ready;
  logic [COLS-1:0]  tx_data;
  logic [ROW_W-1:0] tx_row;
  logic             tx_sof;
  logic             tx_eof;
  logic             tx_full;

  modport master (
    output tx_valid, tx_data, tx_row, tx_sof, tx_eof, tx_full,
    input  tx_ready
  );

  modport slave (
    input  tx_valid, tx_data, tx_row, tx_sof, tx_eof, tx_full,
    output tx_ready
  );

endinterface

// File: rtl/board_snap_reg.sv
// Board snapshot register with a row mux; holds the frame in flight independent of board_in.
module board_snap_reg
  import tetris_pkg::*;
(
  input  logic               clka,
  input  logic               restart,
  input  logic               load,
  input  logic [BOARD_W-1:0] board_in,
  input  logic [ROW_W-1:0]   sel,
  output logic [COLS-1:0]    row_c
);

  logic [BOARD_W-1:0] snap_q;
  logic [BOARD_W-1:0] snap_d;

  always_comb begin
    snap_d = snap_q;
    if (load) snap_d = board_in;
  end

  always_ff @(posedge clka) begin
    if (restart) snap_q <= '0;
    else         snap_q <= snap_d;
  end

  assign row_c = row_slice(snap_q, sel);

endmodule

// File: rtl/board_row_tx.sv
// Board row transmitter: snapshots the board on GEN entry or refresh and streams it row by row.
module board_row_tx
  import tetris_pkg::*;
#(
  parameter int unsigned GAP_CYC = GAP_CYC_DEF
) (
  input  logic                clka,
  input  logic                restart,
  input  logic [ST_W-1:0]     state,
  input  logic [BOARD_W-1:0]  board_in,
  input  logic                error,
  input  logic                refresh,
  board_row_tx_if.master      tx,
  output logic                busy,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [ST_W-1:0]   prev_state_q, prev_state_d;
  logic              pending_q, pending_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  beat_t             beat_q, beat_d;

  logic              trig;
  logic              trig_ok;
  logic              handshake;
  logic              gap_done;
  logic              last_row;
  logic              drop_inc;
  logic              snap_load;
  logic [ROW_W-1:0]  snap_sel;
  logic [COLS-1:0]   snap_row_c;
  beat_t             first_beat;

  // The mux looks one row ahead so the next beat is registered on the accepting edge.
  assign snap_sel = ROW_W'(beat_q.row + ROW_W'(1));

  board_snap_reg u_snap (
    .clka     (clka),
    .restart  (restart),
    .load     (snap_load),
    .board_in (board_in),
    .sel      (snap_sel),
    .row_c    (snap_row_c)
  );

  always_comb begin
    trig       = ((state == ST_GEN) && (prev_state_q != ST_GEN)) || refresh;
    trig_ok    = trig && !error;
    handshake  = valid_q && tx.tx_ready;
    gap_done   = (gap_q == GAP_W'(GAP_CYC - 1));
    last_row   = (beat_q.row == ROW_W'(ROWS - 1));
    first_beat = make_beat(row_slice(board_in, ROW_W'(0)), ROW_W'(0));
  end

  // Next-state, trigger bookkeeping and beat sequencing.
  always_comb begin
    fsm_d        = fsm_q;
    prev_state_d = state;
    pending_d    = pending_q;
    gap_d        = gap_q;
    valid_d      = valid_q;
    beat_d       = beat_q;
    snap_load    = 1'b0;
    drop_inc     = trig && error;

    unique case (fsm_q)
      S_IDLE: begin
        if (trig_ok) begin
          fsm_d     = S_SEND;
          valid_d   = 1'b1;
          snap_load = 1'b1;
          beat_d    = first_beat;
        end
      end

      S_SEND: begin
        if (trig_ok) begin
          if (pending_q) drop_inc  = 1'b1;
          else           pending_d = 1'b1;
        end
        if (handshake) begin
          if (last_row) begin
            fsm_d   = S_GAP;
            valid_d = 1'b0;
            gap_d   = '0;
          end else begin
            beat_d = make_beat(snap_row_c, snap_sel);
          end
        end
      end

      S_GAP: begin
        gap_d = GAP_W'(gap_q + GAP_W'(1));
        if (gap_done) begin
          gap_d = '0;
          // A queued or just-arrived trigger restarts directly without passing through IDLE.
          if (pending_q || trig_ok) begin
            fsm_d     = S_SEND;
            valid_d   = 1'b1;
            snap_load = 1'b1;
            beat_d    = first_beat;
            pending_d = pending_q && trig_ok;
          end else begin
            fsm_d = S_IDLE;
          end
        end else if (trig_ok) begin
          if (pending_q) drop_inc  = 1'b1;
          else           pending_d = 1'b1;
        end
      end

      default: begin
        fsm_d   = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    drop_d = drop_q;
    if (drop_inc && (drop_q != {DROP_W{1'b1}})) drop_d = DROP_W'(drop_q + DROP_W'(1));

    busy_d = (fsm_d != S_IDLE);
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      fsm_q        <= S_IDLE;
      prev_state_q <= ST_NONE;
      pending_q    <= 1'b0;
      gap_q        <= '0;
      drop_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      beat_q       <= '0;
    end else begin
      fsm_q        <= fsm_d;
      prev_state_q <= prev_state_d;
      pending_q    <= pending_d;
      gap_q        <= gap_d;
      drop_q       <= drop_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      beat_q       <= beat_d;
    end
  end

  assign tx.tx_valid = valid_q;
  assign tx.tx_data  = beat_q.data;
  assign tx.tx_row   = beat_q.row;
  assign tx.tx_sof   = beat_q.sof;
  assign tx.tx_eof   = beat_q.eof;
  assign tx.tx_full  = beat_q.full;
  assign busy        = busy_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_board_row_tx.sv
// Directed self-checking bench for board_row_tx with hand-computed beat sequences.
module tb_board_row_tx;
  import tetris_pkg::*;

  logic               clka = 1'b0;
  logic               restart;
  logic [ST_W-1:0]    state;
  logic [BOARD_W-1:0] board_in;
  logic               error;
  logic               refresh;
  logic               busy;
  logic [DROP_W-1:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  board_row_tx_if tx_if ();

  board_row_tx dut (
    .clka     (clka),
    .restart  (restart),
    .state    (state),
    .board_in (board_in),
    .error    (error),
    .refresh  (refresh),
    .tx       (tx_if.master),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #5 clka = ~clka;

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic test_reset();
    restart = 1'b1; state = ST_MOVING; board_in = '0; error = 1'b0; refresh = 1'b0;
    tx_if.tx_ready = 1'b0;
    step(); step();
    restart = 1'b0;
    n_cmp++; if (tx_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", tx_if.tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    n_cmp++; if (tx_if.tx_sof !== 1'b0) begin n_err++; $display("FAIL reset_sof: got %b want 0", tx_if.tx_sof); end
    step();
    n_cmp++; if (tx_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid: got %b want 0", tx_if.tx_valid); end
  endtask

  task automatic test_full_rate();
    logic [3:0] e [8] = '{4'h0, 4'h0, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE};
    board_in = 32'hEEEEEE00; tx_if.tx_ready = 1'b1;
    state = ST_CLEAR; step();
    state = ST_GEN;   step();
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (tx_if.tx_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid[%0d]: got %b want 1", k, tx_if.tx_valid); end
      n_cmp++; if (tx_if.tx_row !== 3'(k)) begin n_err++; $display("FAIL t1_row[%0d]: got %0d want %0d", k, tx_if.tx_row, k); end
      n_cmp++; if (tx_if.tx_data !== e[k]) begin n_err++; $display("FAIL t1_data[%0d]: got %h want %h", k, tx_if.tx_data, e[k]); end
      n_cmp++; if (tx_if.tx_sof !== (k == 0)) begin n_err++; $display("FAIL t1_sof[%0d]: got %b", k, tx_if.tx_sof); end
      n_cmp++; if (tx_if.tx_eof !== (k == 7)) begin n_err++; $display("FAIL t1_eof[%0d]: got %b", k, tx_if.tx_eof); end
      n_cmp++; if (tx_if.tx_full !== 1'b0) begin n_err++; $display("FAIL t1_full[%0d]: got %b want 0", k, tx_if.tx_full); end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (tx_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL t1_gap_valid[%0d]: got %b want 0", i, tx_if.tx_valid); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_gap_busy[%0d]: got %b want 1", i, busy); end
      step();
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t1_idle_busy: got %b want 0", busy); end
    state = ST_MOVING; step();
  endtask

  task automatic test_backpressure();
    logic [3:0] e [8] = '{4'hD, 4'hC, 4'hD, 4'hF, 4'hF, 4'hA, 4'hB, 4'hA};
    board_in = 32'hABAFFDCD; tx_if.tx_ready = 1'b0;
    refresh = 1'b1; step();
    refresh = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (tx_if.tx_valid !== 1'b1) begin n_err++; $display("FAIL t2_valid[%0d]: got %b want 1", k, tx_if.tx_valid); end
      n_cmp++; if (tx_if.tx_data !== e[k]) begin n_err++; $display("FAIL t2_data[%0d]: got %h want %h", k, tx_if.tx_data, e[k]); end
      n_cmp++; if (tx_if.tx_full !== (k == 3 || k == 4)) begin n_err++; $display("FAIL t2_full[%0d]: got %b", k, tx_if.tx_full); end
      if (k == 2) board_in = 32'h00000000;
      step();
      n_cmp++; if (tx_if.tx_row !== 3'(k)) begin n_err++; $display("FAIL t2_hold_row[%0d]: got %0d want %0d", k, tx_if.tx_row, k); end
      n_cmp++; if (tx_if.tx_data !== e[k]) begin n_err++; $display("FAIL t2_hold_data[%0d]: got %h want %h", k, tx_if.tx_data, e[k]); end
      tx_if.tx_ready = 1'b1; step();
      tx_if.tx_ready = 1'b0;
    end
    n_cmp++; if (tx_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL t2_end_valid: got %b want 0", tx_if.tx_valid); end
    step(); step(); step(); step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t2_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_pending();
    board_in = 32'h12345678; tx_if.tx_ready = 1'b1;
    refresh = 1'b1; step();              // frame starts, row 0
    refresh = 1'b0; step();              // row 1
    refresh = 1'b1; step();              // queued, row 2
    refresh = 1'b0; step();              // row 3
    refresh = 1'b1; step();              // dropped, row 4
    refresh = 1'b0; state = ST_GEN; step(); // dropped, row 5
    n_cmp++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL t3_drop: got %0d want 2", drop_cnt); end
    n_cmp++; if (tx_if.tx_data !== 4'h3) begin n_err++; $display("FAIL t3_row5: got %h want 3", tx_if.tx_data); end
    board_in = 32'h9ABCDEF1;
    step(); step();
    n_cmp++; if (tx_if.tx_data !== 4'h1 || tx_if.tx_eof !== 1'b1) begin n_err++; $display("FAIL t3_row7: got data %h eof %b want 1/1", tx_if.tx_data, tx_if.tx_eof); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (tx_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL t3_gap[%0d]: got %b want 0", i, tx_if.tx_valid); end
    end
    step();
    n_cmp++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_sof !== 1'b1 || tx_if.tx_data !== 4'h1) begin n_err++; $display("FAIL t3_restart: got v%b sof%b data %h want 1/1/1", tx_if.tx_valid, tx_if.tx_sof, tx_if.tx_data); end
    step();
    n_cmp++; if (tx_if.tx_row !== 3'd1 || tx_if.tx_data !== 4'hF) begin n_err++; $display("FAIL t3_fresh_row1: got row %0d data %h want 1/F", tx_if.tx_row, tx_if.tx_data); end
    for (int i = 0; i < 11; i++) step();
    n_cmp++; if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL t3_idle: got busy %b valid %b want 0/0", busy, tx_if.tx_valid); end
    n_cmp++; if (drop_cnt !== 8'd2) begin n_err++; $display("FAIL t3_drop_end: got %0d want 2", drop_cnt); end
    state = ST_MOVING; step();
  endtask

  task automatic test_restart_mid();
    board_in = 32'h76543210; tx_if.tx_ready = 1'b1;
    state = ST_GEN; step();
    step(); step(); step(); step();
    n_cmp++; if (tx_if.tx_row !== 3'd4 || tx_if.tx_data !== 4'h4) begin n_err++; $display("FAIL t4_row4: got row %0d data %h want 4/4", tx_if.tx_row, tx_if.tx_data); end
    restart = 1'b1; step();
    restart = 1'b0;
    n_cmp++; if (tx_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL t4_valid: got %b want 0", tx_if.tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t4_busy: got %b want 0", busy); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL t4_drop: got %0d want 0", drop_cnt); end
    step();
    n_cmp++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_row !== 3'd0 || tx_if.tx_sof !== 1'b1) begin n_err++; $display("FAIL t4_new_frame: got v%b row %0d sof %b want 1/0/1", tx_if.tx_valid, tx_if.tx_row, tx_if.tx_sof); end
    for (int i = 0; i < 12; i++) step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t4_idle: got %b want 0", busy); end
  endtask

  task automatic test_error();
    state = ST_MOVING; step();
    error = 1'b1; state = ST_GEN; step();
    n_cmp++; if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL t5_no_frame: got v%b busy%b want 0/0", tx_if.tx_valid, busy); end
    n_cmp++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL t5_drop: got %0d want 1", drop_cnt); end
    step();
    n_cmp++; if (tx_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL t5_still_idle: got %b want 0", tx_if.tx_valid); end
    error = 1'b0; refresh = 1'b1; board_in = 32'hF0F0F0F0; step();
    refresh = 1'b0;
    n_cmp++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 4'h0 || tx_if.tx_full !== 1'b0) begin n_err++; $display("FAIL t5_row0: got v%b data %h full %b want 1/0/0", tx_if.tx_valid, tx_if.tx_data, tx_if.tx_full); end
    step();
    n_cmp++; if (tx_if.tx_data !== 4'hF || tx_if.tx_full !== 1'b1) begin n_err++; $display("FAIL t5_row1: got data %h full %b want F/1", tx_if.tx_data, tx_if.tx_full); end
    for (int i = 0; i < 11; i++) step();
    n_cmp++; if (busy !== 1'b0 || drop_cnt !== 8'd1) begin n_err++; $display("FAIL t5_end: got busy %b drop %0d want 0/1", busy, drop_cnt); end
  endtask

  task automatic test_gen_held();
    int beats = 0;
    int sofs  = 0;
    state = ST_MOVING; tx_if.tx_ready = 1'b1; step();
    state = ST_GEN;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_if.tx_valid === 1'b1) beats++;
      if (tx_if.tx_valid === 1'b1 && tx_if.tx_sof === 1'b1) sofs++;
    end
    n_cmp++; if (beats !== 8) begin n_err++; $display("FAIL t6_beats: got %0d want 8", beats); end
    n_cmp++; if (sofs !== 1) begin n_err++; $display("FAIL t6_frames: got %0d want 1", sofs); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t6_idle: got %b want 0", busy); end
  endtask

  task automatic test_drop_saturate();
    state = ST_MOVING; error = 1'b1; refresh = 1'b1;
    for (int i = 0; i < 260; i++) step();
    error = 1'b0; refresh = 1'b0;
    n_cmp++; if (drop_cnt !== 8'hFF) begin n_err++; $display("FAIL sat_drop: got %0d want 255", drop_cnt); end
    n_cmp++; if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL sat_idle: got v%b busy%b want 0/0", tx_if.tx_valid, busy); end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_pending();
    test_restart_mid();
    test_error();
    test_gen_held();
    test_drop_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
